fpu_16_bit: RTL and testbench
=============================

# fpu_16_bit

Sequential IEEE-754 half-precision (binary16) arithmetic unit that adds, subtracts, multiplies or divides two operands and also reports their magnitude ordering. Each operation starts when reset is released and finishes by raising `done`. The result is truncated, with no rounding. Overflow and underflow are reported on a 2-bit flag. The block sits as a leaf datapath unit that a controller restarts per operation via reset.

## Interface
- No parameters. Format is fixed: sign[15], exponent[14:10] with bias 15, fraction[9:0] with hidden 1.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; low clears state, high releases and starts an operation
- `X`  in  16  operand A (binary16)
- `Y`  in  16  operand B (binary16)
- `opcode`  in  2  0 = X+Y, 1 = X−Y, 2 = X×Y, 3 = X÷Y
- `result`  out  16  binary16 result, registered
- `OFUF`  out  2  [1] = overflow, [0] = underflow; registered
- `done`  out  1  high once `result`, `OFUF` and `compResult` are valid; stays high until next reset
- `compResult`  out  3  {X>Y, X==Y, X<Y}, numeric compare, registered

## Operation
**Reset**
- While `reset` is low, every output reads 0 and the FSM sits in IDLE.

**FSM**
- States: IDLE → UNPACK → EXEC → NORM → DONE.
- **IDLE:** left on the first rising edge with `reset` high.
- **UNPACK:**
  - Capture X, Y and opcode. Later input changes are ignored until the next reset.
  - Split each operand into sign, exponent and 11-bit significand.
  - An exponent field of 0 means the operand is zero; subnormals are flushed.
  - Compute `compResult` with +0 equal to −0.
- **EXEC, add/sub:**
  - Subtract is addition with Y's sign inverted.
  - Align the smaller-exponent significand by right shift. A shift of 13 or more zeroes it.
  - Add or subtract the magnitudes, keeping 3 extra low bits. The sign is that of the larger magnitude.
  - An exact-zero result gives +0.
- **EXEC, mul:**
  - 11×11 significand product.
  - Exponent = eX + eY − 15; sign = XOR of the operand signs.
- **EXEC, div:**
  - Restoring division, one quotient bit per cycle, 12 iterations.
  - Exponent = eX − eY + 15; sign = XOR of the operand signs.
- **NORM:**
  - Shift the leading 1 into the hidden position, adjusting the exponent.
  - Truncate the fraction to 10 bits; discarded bits are dropped with no rounding.
  - Pack the result.
- **DONE:** hold all outputs and assert `done`.

**Exceptions**
- Overflow (final exponent > 30, or divide by zero with nonzero X):
  - `result` = {sign, 5'h1F, 10'h000}, `OFUF` = 2'b10.
- Underflow (final exponent < 1 with a nonzero true result):
  - `result` = {sign, 15'h0000}, `OFUF` = 2'b01.
- Zero operand in mul, or X = 0 in div: `result` = +0, `OFUF` = 0.
- Inf/NaN encodings get no special treatment; exponent 31 is handled as an ordinary exponent.

## Timing
- The cycle count starts at the first rising edge after `reset` goes high.
- Add, sub, mul: UNPACK (1) + EXEC (1) + NORM (1). `done` is high after the 3rd edge.
- Div: UNPACK (1) + EXEC (12) + NORM (1). `done` is high after the 14th edge.
- Div early exit: if UNPACK finds the exponent must overflow or underflow (eX − eY + 15 > 31 or < 0), or Y = 0, it goes straight to DONE with flags set. `done` is high after the 2nd edge.
- `result`, `OFUF` and `compResult` change only on the edge that enters DONE (`compResult` may be written in UNPACK).
- Reset asserted mid-operation aborts immediately (asynchronous) and clears all outputs. No partial result is ever visible.
- There is no other handshake. A new operation needs a reset low pulse of at least one cycle.

## Test plan
- Add: opcode 0, X=0x0F00, Y=0x0B80 → `result` 0x1160, `OFUF` 0, `done` after 3 cycles. Then X=0xD98D, Y=0x4F08 → 0xD8AC.
- Sub: opcode 1:
  - X=0xD98D, Y=0x4F08 → 0xDA6E.
  - X=0x118D, Y=0xEF08 → 0x6F08 (X negligible).
  - X=0x418D, Y=0xB308 → 0x41FD (truncated).
- Mul: opcode 2:
  - X=0x4F00, Y=0x0B80 → 0x1E90.
  - X=0xD98D, Y=0x4F08 → 0xECE0.
  - X=Y=0x50BB → 0x6598.
  - `compResult` 3'b010 on the equal pair.
- Div: opcode 3:
  - X=0xD98D, Y=0x4F08 → 0xC650 after 14 cycles.
  - X=0x418D, Y=0xB308 → 0xCA50.
  - X=0x118D, Y=0xEF08 → `OFUF` 2'b01, `result` 0x8000, `done` after 2 cycles.
- Exceptions: mul X=Y=0x7800 → `OFUF` 2'b10, `result` 0x7C00. Div X=0x3C00, Y=0x0000 → `OFUF` 2'b10, `result` 0x7C00.
- Reset: drive `reset` low during a divide's EXEC → all outputs 0 at once. On release the unit recomputes from the current inputs.

Source files
------------

// File: rtl/fpu_16_bit.sv
// Sequential binary16 add/sub/mul/div with magnitude compare; one operation per reset release.
// 3 edges for add/sub/mul, 14 for divide (2 on early exit); no handshake, truncating.
module fpu_16_bit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic [1:0]  opcode,
  output logic [15:0] result,
  output logic [1:0]  OFUF,
  output logic        done,
  output logic [2:0]  compResult
);

  typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, DONE} state_t;

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  state_t             state_q;
  logic [1:0]         op_q;
  logic               xs_q, ys_q;
  logic [4:0]         xe_q, ye_q;
  logic [10:0]        xm_q, ym_q;
  logic [2:0]         cmp_q;
  logic               rs_q;
  logic signed [7:0]  re_q;
  logic [23:0]        m_q;
  logic [12:0]        rem_q;
  logic [11:0]        quo_q;
  logic [3:0]         cnt_q;
  logic [15:0]        result_q;
  logic [1:0]         ofuf_q;
  logic               done_q;
  logic [2:0]         comp_q;

  // Compare on live inputs; exponent 0 maps to zero so +0 and -0 tie.
  logic signed [16:0] xv, yv;
  logic [2:0]         cmp_d;

  always_comb begin
    xv = '0;
    yv = '0;
    if (X[14:10] != 5'd0)
      xv = X[15] ? -$signed({2'b00, X[14:0]}) : $signed({2'b00, X[14:0]});
    if (Y[14:10] != 5'd0)
      yv = Y[15] ? -$signed({2'b00, Y[14:0]}) : $signed({2'b00, Y[14:0]});
    cmp_d = {xv > yv, xv == yv, xv < yv};
  end

  // Add/sub: align smaller magnitude with 3 guard bits, then add or subtract.
  logic        eff_ys, x_big, b_s;
  logic [4:0]  b_e, s_e, sh;
  logic [10:0] b_m, s_m;
  logic [13:0] b_ext, s_ext;
  logic [14:0] sum_d;

  always_comb begin
    eff_ys = ys_q ^ (op_q == OP_SUB);
    x_big  = {xe_q, xm_q} >= {ye_q, ym_q};
    b_s    = x_big ? xs_q : eff_ys;
    b_e    = x_big ? xe_q : ye_q;
    s_e    = x_big ? ye_q : xe_q;
    b_m    = x_big ? xm_q : ym_q;
    s_m    = x_big ? ym_q : xm_q;
    sh     = b_e - s_e;
    b_ext  = {b_m, 3'b000};
    s_ext  = (sh >= 5'd13) ? 14'd0 : ({s_m, 3'b000} >> sh);
    if (xs_q == eff_ys)
      sum_d = {1'b0, b_ext} + {1'b0, s_ext};
    else
      sum_d = {1'b0, b_ext} - {1'b0, s_ext};
  end

  logic [21:0]       prod_d;
  logic signed [7:0] mul_e, div_e;
  logic              div_early;

  always_comb begin
    prod_d    = {11'd0, xm_q} * {11'd0, ym_q};
    mul_e     = $signed({3'b000, xe_q}) + $signed({3'b000, ye_q}) - 8'sd15;
    div_e     = $signed({3'b000, xe_q}) - $signed({3'b000, ye_q}) + 8'sd15;
    div_early = (ye_q == 5'd0) || (div_e > 8'sd31) || (div_e < 8'sd0);
  end

  // One restoring-division step; the first step seeds from the dividend.
  logic [12:0] rem_in, rem_sub, rem_d;
  logic [11:0] quo_in, quo_d;
  logic        ge;

  always_comb begin
    rem_in  = (state_q == UNPACK) ? {2'b00, xm_q} : rem_q;
    quo_in  = (state_q == UNPACK) ? 12'd0 : quo_q;
    ge      = rem_in >= {2'b00, ym_q};
    rem_sub = ge ? (rem_in - {2'b00, ym_q}) : rem_in;
    rem_d   = rem_sub << 1;
    quo_d   = 12'({quo_in, ge});
  end

  logic [15:0] early_res;
  logic [1:0]  early_ofuf;

  always_comb begin
    early_res  = {xs_q ^ ys_q, 15'h0000};
    early_ofuf = 2'b01;
    if (xm_q == 11'd0) begin
      early_res  = 16'h0000;
      early_ofuf = 2'b00;
    end else if ((ye_q == 5'd0) || (div_e > 8'sd31)) begin
      early_res  = {xs_q ^ ys_q, 5'h1F, 10'h000};
      early_ofuf = 2'b10;
    end
  end

  // Raw significands are stored with the nominal hidden bit at m_q[22].
  logic [4:0]        lead;
  logic [23:0]       norm_sh;
  logic [9:0]        frac;
  logic signed [7:0] fe;
  logic [15:0]       norm_res;
  logic [1:0]        norm_ofuf;

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 24; i++)
      if (m_q[i]) lead = 5'(i);
    norm_sh   = m_q << (5'd23 - lead);
    frac      = 10'(norm_sh >> 13);
    fe        = re_q + $signed({3'b000, lead}) - 8'sd22;
    norm_res  = {rs_q, fe[4:0], frac};
    norm_ofuf = 2'b00;
    if (m_q == 24'd0) begin
      norm_res = 16'h0000;
    end else if (fe > 8'sd30) begin
      norm_res  = {rs_q, 5'h1F, 10'h000};
      norm_ofuf = 2'b10;
    end else if (fe < 8'sd1) begin
      norm_res  = {rs_q, 15'h0000};
      norm_ofuf = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      xs_q     <= 1'b0;
      ys_q     <= 1'b0;
      xe_q     <= '0;
      ye_q     <= '0;
      xm_q     <= '0;
      ym_q     <= '0;
      cmp_q    <= '0;
      rs_q     <= 1'b0;
      re_q     <= '0;
      m_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ofuf_q   <= '0;
      done_q   <= 1'b0;
      comp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          op_q    <= opcode;
          xs_q    <= X[15];
          ys_q    <= Y[15];
          xe_q    <= X[14:10];
          ye_q    <= Y[14:10];
          xm_q    <= (X[14:10] == 5'd0) ? 11'd0 : {1'b1, X[9:0]};
          ym_q    <= (Y[14:10] == 5'd0) ? 11'd0 : {1'b1, Y[9:0]};
          cmp_q   <= cmp_d;
          state_q <= UNPACK;
        end
        UNPACK: begin
          case (op_q)
            OP_DIV: begin
              if (div_early) begin
                result_q <= early_res;
                ofuf_q   <= early_ofuf;
                comp_q   <= cmp_q;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end else begin
                rem_q   <= rem_d;
                quo_q   <= quo_d;
                cnt_q   <= 4'd1;
                rs_q    <= xs_q ^ ys_q;
                re_q    <= div_e;
                state_q <= EXEC;
              end
            end
            OP_MUL: begin
              rs_q    <= xs_q ^ ys_q;
              re_q    <= mul_e;
              m_q     <= {prod_d, 2'b00};
              state_q <= NORM;
            end
            default: begin
              rs_q    <= b_s;
              re_q    <= $signed({3'b000, b_e});
              m_q     <= {sum_d, 9'd0};
              state_q <= NORM;
            end
          endcase
        end
        EXEC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd11) begin
            m_q     <= {1'b0, quo_d, 11'd0};
            state_q <= NORM;
          end
        end
        NORM: begin
          result_q <= norm_res;
          ofuf_q   <= norm_ofuf;
          comp_q   <= cmp_q;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result     = result_q;
  assign OFUF       = ofuf_q;
  assign done       = done_q;
  assign compResult = comp_q;

endmodule

// File: tb/tb_fpu_16_bit.sv
// Directed-vector bench for fpu_16_bit: per-vector reset pulse, latency, result, flags and compare,
// plus hold, asynchronous clear and mid-divide abort sequences.
module tb_fpu_16_bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] X = 16'h0000;
  logic [15:0] Y = 16'h0000;
  logic [1:0]  opcode = 2'd0;
  logic [15:0] result;
  logic [1:0]  OFUF;
  logic        done;
  logic [2:0]  compResult;

  int checks = 0;
  int errors = 0;

  fpu_16_bit dut (
    .clk       (clk),
    .reset     (reset),
    .X         (X),
    .Y         (Y),
    .opcode    (opcode),
    .result    (result),
    .OFUF      (OFUF),
    .done      (done),
    .compResult(compResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] res;
    logic [1:0]  ofuf;
    logic [2:0]  cmp;
    int          cyc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count edges after release until done; inputs are scrambled once captured.
  task automatic wait_done(output int cyc, output logic partial);
    cyc     = -1;
    partial = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        X      = 16'($urandom);
        Y      = 16'($urandom);
        opcode = 2'($urandom);
      end
      if (done) begin
        cyc = n;
        break;
      end
      if (result !== 16'h0 || OFUF !== 2'b0 || compResult !== 3'b0) partial = 1'b1;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        output int cyc, output logic partial);
    @(negedge clk);
    reset  = 1'b0;
    opcode = op;
    X      = x;
    Y      = y;
    @(negedge clk);
    reset = 1'b1;
    wait_done(cyc, partial);
  endtask

  initial begin
    int   cyc;
    logic partial;

    vecs[0]  = '{2'd0, 16'h0F00, 16'h0B80, 16'h1160, 2'b00, 3'b100, 3};
    vecs[1]  = '{2'd0, 16'hD98D, 16'h4F08, 16'hD8AC, 2'b00, 3'b001, 3};
    vecs[2]  = '{2'd1, 16'hD98D, 16'h4F08, 16'hDA6E, 2'b00, 3'b001, 3};
    vecs[3]  = '{2'd1, 16'h118D, 16'hEF08, 16'h6F08, 2'b00, 3'b100, 3};
    vecs[4]  = '{2'd1, 16'h418D, 16'hB308, 16'h41FD, 2'b00, 3'b100, 3};
    vecs[5]  = '{2'd2, 16'h4F00, 16'h0B80, 16'h1E90, 2'b00, 3'b100, 3};
    vecs[6]  = '{2'd2, 16'hD98D, 16'h4F08, 16'hECE0, 2'b00, 3'b001, 3};
    vecs[7]  = '{2'd2, 16'h50BB, 16'h50BB, 16'h6598, 2'b00, 3'b010, 3};
    vecs[8]  = '{2'd3, 16'hD98D, 16'h4F08, 16'hC650, 2'b00, 3'b001, 14};
    vecs[9]  = '{2'd3, 16'h418D, 16'hB308, 16'hCA50, 2'b00, 3'b100, 14};
    vecs[10] = '{2'd3, 16'h118D, 16'hEF08, 16'h8000, 2'b01, 3'b100, 2};
    vecs[11] = '{2'd2, 16'h7800, 16'h7800, 16'h7C00, 2'b10, 3'b010, 3};
    vecs[12] = '{2'd3, 16'h3C00, 16'h0000, 16'h7C00, 2'b10, 3'b100, 2};
    vecs[13] = '{2'd0, 16'h0000, 16'h8000, 16'h0000, 2'b00, 3'b010, 3};
    vecs[14] = '{2'd1, 16'h3C00, 16'h3C00, 16'h0000, 2'b00, 3'b010, 3};
    vecs[15] = '{2'd2, 16'h0000, 16'h4000, 16'h0000, 2'b00, 3'b001, 3};
    vecs[16] = '{2'd2, 16'h8400, 16'h0400, 16'h8000, 2'b01, 3'b001, 3};
    vecs[17] = '{2'd0, 16'h7800, 16'h7800, 16'h7C00, 2'b10, 3'b010, 3};
    vecs[18] = '{2'd3, 16'h3C00, 16'h3E00, 16'h3955, 2'b00, 3'b001, 14};
    vecs[19] = '{2'd3, 16'h3C00, 16'h3C00, 16'h3C00, 2'b00, 3'b010, 14};
    vecs[20] = '{2'd1, 16'h3C00, 16'h0800, 16'h3C00, 2'b00, 3'b100, 3};
    vecs[21] = '{2'd1, 16'h3C00, 16'h0C00, 16'h3BFF, 2'b00, 3'b100, 3};

    #2 reset = 1'b0;
    #10;
    chk("reset_state", {10'd0, done, OFUF, result, compResult}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, cyc, partial);
      chk($sformatf("v%0d cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("v%0d result", i), {16'd0, result}, {16'd0, vecs[i].res});
      chk($sformatf("v%0d ofuf", i), {30'd0, OFUF}, {30'd0, vecs[i].ofuf});
      chk($sformatf("v%0d cmp", i), {29'd0, compResult}, {29'd0, vecs[i].cmp});
      chk($sformatf("v%0d partial", i), {31'd0, partial}, 32'd0);
    end

    // Outputs hold in DONE despite changing inputs.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", {16'd0, result}, {16'd0, vecs[NV-1].res});
    chk("hold_done", {31'd0, done}, 32'd1);

    // Asynchronous clear between clock edges.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_clear", {10'd0, done, OFUF, result, compResult}, 32'd0);

    // Abort a divide mid-iteration, then recompute from the new inputs.
    opcode = 2'd3;
    X      = 16'hD98D;
    Y      = 16'h4F08;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_div_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("abort_clear", {10'd0, done, OFUF, result, compResult}, 32'd0);
    opcode = 2'd2;
    X      = 16'h50BB;
    Y      = 16'h50BB;
    @(negedge clk);
    reset = 1'b1;
    wait_done(cyc, partial);
    chk("abort_rerun_cycles", 32'(cyc), 32'd3);
    chk("abort_rerun_result", {16'd0, result}, 32'h6598);
    chk("abort_rerun_cmp", {29'd0, compResult}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
